// File: rtl/uart_parity_pkg.sv
// Shared encodings for the UART parity unit: parity modes and checker FSM states.
package uart_parity_pkg;

    // Parity mode encoding as presented on par_mode.
    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    // Serial checker states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10
    } chk_state_e;

endpackage

// File: rtl/uart_parity_unit_if.sv
// Bus bundle for the UART parity unit: generator, checker and error counter signals.
//
// Handshake semantics: there is no backpressure. load, frame_start, sample_en
// and err_clr are single-cycle strobes that the unit always accepts on the
// rising edge where they are high. gen_valid, check_done and par_err are
// single-cycle registered pulses; parity_bit and err_cnt hold their values.
interface uart_parity_unit_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) ();
    // Tx generator
    logic                     par_en;
    logic [1:0]               par_mode;
    logic                     load;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     parity_bit;
    logic                     gen_valid;
    // Rx checker
    logic                     frame_start;
    logic                     sample_en;
    logic                     rx_bit;
    logic                     busy;
    logic                     check_done;
    logic                     par_err;
    // Error counter
    logic                     err_clr;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    // Debug view of the checker FSM
    uart_parity_pkg::chk_state_e chk_state;

    modport slave (
        input  par_en, par_mode, load, data_in, frame_start, sample_en, rx_bit, err_clr,
        output parity_bit, gen_valid, busy, check_done, par_err, err_cnt, chk_state
    );

    modport master (
        output par_en, par_mode, load, data_in, frame_start, sample_en, rx_bit, err_clr,
        input  parity_bit, gen_valid, busy, check_done, par_err, err_cnt, chk_state
    );
endinterface

// File: rtl/parity_bit_calc.sv
// Turns an XOR-reduction of data bits plus a parity mode into the parity bit.
module parity_bit_calc
    import uart_parity_pkg::*;
(
    input  logic       xor_i,
    input  logic [1:0] mode_i,
    output logic       par_o
);

    // Mode decode: even passes the XOR, odd inverts it, mark/space are constant.
    always_comb begin
        par_o = 1'b0;
        case (mode_i)
            PAR_EVEN:  par_o = xor_i;
            PAR_ODD:   par_o = ~xor_i;
            PAR_MARK:  par_o = 1'b1;
            PAR_SPACE: par_o = 1'b0;
            default:   par_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_parity_unit.sv
// UART parity unit: Tx parity generator, serial Rx parity checker and a
// saturating parity-error counter. Generator and checker run independently.
module uart_parity_unit
    import uart_parity_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_parity_unit_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    logic gen_xor;
    logic gen_par;
    logic parity_bit_q, parity_bit_d;
    logic gen_valid_q,  gen_valid_d;

    assign gen_xor = ^bus.data_in;

    parity_bit_calc u_gen_calc (
        .xor_i  (gen_xor),
        .mode_i (bus.par_mode),
        .par_o  (gen_par)
    );

    // Capture parity on load; without parity enabled the bit is forced low.
    always_comb begin
        parity_bit_d = parity_bit_q;
        gen_valid_d  = bus.load;
        if (bus.load) begin
            parity_bit_d = bus.par_en & gen_par;
        end
    end

    // Generator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit_q <= 1'b0;
            gen_valid_q  <= 1'b0;
        end else begin
            parity_bit_q <= parity_bit_d;
            gen_valid_q  <= gen_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             xor_q,   xor_d;
    logic [1:0]       mode_q,  mode_d;
    logic             pen_q,   pen_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic             exp_par;

    // Expected parity for the frame uses the mode latched at frame start.
    parity_bit_calc u_chk_calc (
        .xor_i  (xor_q),
        .mode_i (mode_q),
        .par_o  (exp_par)
    );

    // Checker next-state: frame_start always (re)starts a frame, even mid-frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        mode_d  = mode_q;
        pen_d   = pen_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.frame_start) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            xor_d   = 1'b0;
            mode_d  = bus.par_mode;
            pen_d   = bus.par_en;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (bus.sample_en) begin
                        xor_d = xor_q ^ bus.rx_bit;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            if (pen_q) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (bus.sample_en) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = (bus.rx_bit != exp_par);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Checker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xor_q   <= 1'b0;
            mode_q  <= 2'b00;
            pen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            mode_q  <= mode_d;
            pen_q   <= pen_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Error counter: counts visible par_err pulses, saturates, clear wins.
    // ------------------------------------------------------------------
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Next count value.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.parity_bit = parity_bit_q;
    assign bus.gen_valid  = gen_valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.check_done = done_q;
    assign bus.par_err    = err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.chk_state  = state_q;

endmodule
